// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
// Contents:
//   conv_state_t  - state encoding of the sequential binary-to-BCD engine
//   GLYPH_*       - active-high segment patterns, bit order {g,f,e,d,c,b,a}
//   MSG_GLYPH     - message-mode glyphs per digit ("donE" on digits 3..0)
//   dec_glyph()   - decimal digit to glyph lookup
//   bcd_digits()  - decimal digits needed to represent any w-bit value
package seg_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [6:0] GLYPH_LET_D = 7'b1011110;
  localparam logic [6:0] GLYPH_LET_O = 7'b1011100;
  localparam logic [6:0] GLYPH_LET_N = 7'b1010100;
  localparam logic [6:0] GLYPH_LET_E = 7'b1111001;

  // Index 0 is the rightmost digit.
  localparam logic [6:0] MSG_GLYPH [0:7] = '{
    GLYPH_LET_E, GLYPH_LET_N, GLYPH_LET_O, GLYPH_LET_D,
    GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK, GLYPH_BLANK
  };

  function automatic logic [6:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0:    dec_glyph = GLYPH_0;
      4'd1:    dec_glyph = GLYPH_1;
      4'd2:    dec_glyph = GLYPH_2;
      4'd3:    dec_glyph = GLYPH_3;
      4'd4:    dec_glyph = GLYPH_4;
      4'd5:    dec_glyph = GLYPH_5;
      4'd6:    dec_glyph = GLYPH_6;
      4'd7:    dec_glyph = GLYPH_7;
      4'd8:    dec_glyph = GLYPH_8;
      4'd9:    dec_glyph = GLYPH_9;
      default: dec_glyph = GLYPH_BLANK;
    endcase
  endfunction

  function automatic int bcd_digits(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_mux_scan_driver_bin2bcd.sv
// Sequential double-dabble binary-to-BCD engine.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   start, din     - load strobe and binary value
//   busy           - conversion running or a value is waiting in the pending slot
//   done           - one-cycle pulse while bcd holds a finished result
//   bcd            - NUM_BCD packed BCD nibbles, nibble 0 = units
// A start that arrives while a conversion is running is parked in a one-deep
// pending slot (last strobe wins) and converted right after the current one.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int VALUE_W = 8,
  parameter int NUM_BCD = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [VALUE_W-1:0]     din,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_BCD*4-1:0]   bcd
);

  localparam int BW    = NUM_BCD * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VALUE_W - 1);

  conv_state_t        state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               pend;
  logic [VALUE_W-1:0] pend_val;
  logic [VALUE_W-1:0] bin_sr;
  logic [BW-1:0]      bcd_sr;
  logic [BW-1:0]      bcd_adj;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_SHIFT) bit_cnt <= bit_cnt + 1'b1;
      else                   bit_cnt <= '0;
      // IDLE always consumes whatever is pending.
      if (state == ST_IDLE) pend <= 1'b0;
      else if (start)       pend <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start || pend) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == LAST_BIT) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_BCD; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
  end

  // Datapath registers carry no reset; the control state qualifies them.
  always_ff @(posedge clk) begin
    if (state != ST_IDLE && start) pend_val <= din;
    if (state == ST_IDLE) begin
      bin_sr <= start ? din : pend_val;
      bcd_sr <= '0;
    end else if (state == ST_SHIFT) begin
      bin_sr <= bin_sr << 1;
      bcd_sr <= {bcd_adj[BW-2:0], bin_sr[VALUE_W-1]};
    end
  end

  assign busy = (state != ST_IDLE) | pend;
  assign done = (state == ST_LOAD);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seg_mux_scan_driver.sv
// Time-multiplexed seven-segment display driver with BCD conversion.
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   value           - binary number to display, loaded on value_valid
//   value_valid     - one-cycle load strobe
//   blank_leading   - blank leading zeros (digit 0 always shown)
//   msg_mode        - show the fixed "donE" message instead of the number
//   brightness[3:0] - duty control, present only when SEG_DIM_EN is defined
//   seg_display     - registered segments {g,f,e,d,c,b,a}
//   seg_select      - registered digit enables, bit 0 = rightmost digit
//   busy            - conversion in progress (or pending)
// Optional build macro: SEG_DIM_EN adds the brightness input.
module seg_mux_scan_driver
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int VALUE_W        = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  value_valid,
  input  logic                  blank_leading,
  input  logic                  msg_mode,
`ifdef SEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seg_display,
  output logic [NUM_DIGITS-1:0] seg_select,
  output logic                  busy
);

  // The engine is never narrower than the display so every buffer digit
  // comes straight from a BCD nibble; extra nibbles only feed overflow.
  localparam int BCD_NEED = bcd_digits(VALUE_W);
  localparam int NUM_BCD  = (BCD_NEED > NUM_DIGITS) ? BCD_NEED : NUM_DIGITS;
  localparam int CNT_W    = $clog2(REFRESH_DIV);
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);

  logic                    conv_done;
  logic [NUM_BCD*4-1:0]    conv_bcd;
  logic [NUM_DIGITS*4-1:0] dig_buf;
  logic                    ovf;
  logic                    ovf_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zero_acc;
  logic [6:0]              glyph_p0;
  logic                    sel_on_p0;
  logic [NUM_DIGITS-1:0]   sel_hot_p0;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .NUM_BCD (NUM_BCD)
  ) u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (value_valid),
    .din     (value),
    .busy    (busy),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_comb begin
    ovf_nxt = 1'b0;
    for (int i = NUM_DIGITS; i < NUM_BCD; i++) begin
      if (conv_bcd[i*4 +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
  end

  // Buffer changes only on the LOAD cycle, so partial results never show.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig_buf <= '0;
      ovf     <= 1'b0;
    end else if (conv_done) begin
      dig_buf <= conv_bcd[NUM_DIGITS*4-1:0];
      ovf     <= ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // zero_from[i] = every buffer digit at position >= i is zero.
  always_comb begin
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc & (dig_buf[i*4 +: 4] == 4'd0);
      zero_from[i] = zero_acc;
    end
  end

  // Stage 0: glyph and select for the current counter/index.
  always_comb begin
    if (msg_mode)
      glyph_p0 = MSG_GLYPH[idx];
    else if (ovf)
      glyph_p0 = GLYPH_DASH;
    else if (blank_leading && idx != '0 && zero_from[idx])
      glyph_p0 = GLYPH_BLANK;
    else
      glyph_p0 = dec_glyph(dig_buf[idx*4 +: 4]);
  end

  always_comb begin
    // Counter value 0 is a dark gap between slots to prevent ghosting.
    sel_on_p0 = (cnt != '0);
`ifdef SEG_DIM_EN
    sel_on_p0 = sel_on_p0 &&
                ((32'(cnt) << 4) < (32'(brightness) * 32'(REFRESH_DIV)));
`endif
    sel_hot_p0 = '0;
    if (sel_on_p0) sel_hot_p0[idx] = 1'b1;
  end

  // Stage 1: registered, polarity-adjusted outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_display <= {7{SEG_INV}};
      seg_select  <= {NUM_DIGITS{SEL_INV}};
    end else begin
      seg_display <= glyph_p0 ^ {7{SEG_INV}};
      seg_select  <= sel_hot_p0 ^ {NUM_DIGITS{SEL_INV}};
    end
  end

endmodule

// File: tb/tb_seg_mux_scan_driver.sv
module tb_seg_mux_scan_driver;

  logic        clk;
  logic        reset_n;
  logic [7:0]  value8;
  logic        vv8;
  logic [15:0] value16;
  logic        vv16;
  logic        blank_leading;
  logic        msg_mode;
  logic [6:0]  seg8, seg16;
  logic [3:0]  sel8, sel16;
  logic        busy8, busy16;

  int total = 0;
  int bad   = 0;

  logic [6:0] cap_dig [4];

  seg_mux_scan_driver #(
    .NUM_DIGITS(4), .VALUE_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .value(value8), .value_valid(vv8),
    .blank_leading(blank_leading), .msg_mode(msg_mode),
`ifdef SEG_DIM_EN
    .brightness(4'hF),
`endif
    .seg_display(seg8), .seg_select(sel8), .busy(busy8)
  );

  seg_mux_scan_driver #(
    .NUM_DIGITS(4), .VALUE_W(16), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut16 (
    .clk(clk), .reset_n(reset_n), .value(value16), .value_valid(vv16),
    .blank_leading(blank_leading), .msg_mode(msg_mode),
`ifdef SEG_DIM_EN
    .brightness(4'hF),
`endif
    .seg_display(seg16), .seg_select(sel16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe8(input logic [7:0] v);
    value8 = v;
    vv8 = 1'b1;
    tick;
    vv8 = 1'b0;
  endtask

  task automatic strobe16(input logic [15:0] v);
    value16 = v;
    vv16 = 1'b1;
    tick;
    vv16 = 1'b0;
  endtask

  task automatic wait_idle(input bit use16, input string name);
    int n;
    n = 0;
    while ((use16 ? busy16 : busy8) && n < 100) begin
      tick;
      n++;
    end
    if (use16 ? busy16 : busy8) begin
      total++;
      bad++;
      $display("FAIL %s_idle_timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  // Walk the scan until each digit has been seen selected alone.
  task automatic capture(input bit use16, input string name);
    bit got [4];
    int n;
    logic [3:0] s;
    logic [6:0] g;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      got[i] = 1'b0;
      cap_dig[i] = 7'h00;
    end
    for (int c = 0; c < 64 && n < 4; c++) begin
      s = use16 ? sel16 : sel8;
      g = use16 ? seg16 : seg8;
      for (int i = 0; i < 4; i++) begin
        if ((~s) == (4'b0001 << i) && !got[i]) begin
          got[i] = 1'b1;
          cap_dig[i] = g;
          n++;
        end
      end
      tick;
    end
    if (n < 4) begin
      total++;
      bad++;
      $display("FAIL %s_scan_timeout: saw %0d digits, required 4", name, n);
    end
  endtask

  typedef struct {
    logic [7:0] value;
    logic       bl;
    logic       msg;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  vec_t vecs [8];

  // Sequence monitor for the pending-strobe case.
  logic mon_en = 1'b0;
  logic seen12, seen99, seen55, gap;
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (dut.dig_buf == 16'h0012) seen12 = 1'b1;
      if (dut.dig_buf == 16'h0099) seen99 = 1'b1;
      if (dut.dig_buf == 16'h0055) seen55 = 1'b1;
      if (!busy8 && dut.dig_buf != 16'h0055) gap = 1'b1;
    end
  end

  logic [3:0] sel_exp [8];
  int nb;
  int busy_seen;

  initial begin
    vecs[0] = '{8'd137, 1'b1, 1'b0, 7'h7F,      7'b1111001, 7'b0110000, 7'b1111000};
    vecs[1] = '{8'd137, 1'b0, 1'b0, 7'b1000000, 7'b1111001, 7'b0110000, 7'b1111000};
    vecs[2] = '{8'd0,   1'b1, 1'b0, 7'h7F,      7'h7F,      7'h7F,      7'b1000000};
    vecs[3] = '{8'd0,   1'b0, 1'b0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[4] = '{8'd255, 1'b1, 1'b0, 7'h7F,      7'b0100100, 7'b0010010, 7'b0010010};
    vecs[5] = '{8'd100, 1'b1, 1'b0, 7'h7F,      7'b1111001, 7'b1000000, 7'b1000000};
    vecs[6] = '{8'd8,   1'b1, 1'b1, 7'b0100001, 7'b0100011, 7'b0101011, 7'b0000110};
    vecs[7] = '{8'd9,   1'b1, 1'b0, 7'h7F,      7'h7F,      7'h7F,      7'b0010000};
    sel_exp = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD};

    reset_n = 1'b0;
    value8 = '0; vv8 = 1'b0;
    value16 = '0; vv16 = 1'b0;
    blank_leading = 1'b1;
    msg_mode = 1'b0;
    seen12 = 1'b0; seen99 = 1'b0; seen55 = 1'b0; gap = 1'b0;

    // Reset state held across clock edges.
    repeat (3) tick;
    chk("reset_seg", {25'd0, seg8}, 32'h7F);
    chk("reset_sel", {28'd0, sel8}, 32'hF);
    chk("reset_busy", {31'd0, busy8}, 32'd0);

    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("scan_sel_%0d", i), {28'd0, sel8}, {28'd0, sel_exp[i]});
    end

    // Table-driven conversions.
    for (int v = 0; v < 8; v++) begin
      blank_leading = vecs[v].bl;
      msg_mode = vecs[v].msg;
      strobe8(vecs[v].value);
      if (v == 0) begin
        nb = 0;
        while (busy8 && nb < 50) begin
          nb++;
          tick;
        end
        chk("busy_cycles", nb, 32'd9);
      end
      wait_idle(1'b0, $sformatf("vec%0d", v));
      repeat (2) tick;
      capture(1'b0, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_d3", v), {25'd0, cap_dig[3]}, {25'd0, vecs[v].e3});
      chk($sformatf("vec%0d_d2", v), {25'd0, cap_dig[2]}, {25'd0, vecs[v].e2});
      chk($sformatf("vec%0d_d1", v), {25'd0, cap_dig[1]}, {25'd0, vecs[v].e1});
      chk($sformatf("vec%0d_d0", v), {25'd0, cap_dig[0]}, {25'd0, vecs[v].e0});
    end

    // Overflow on the 16-bit instance, then cleared by an in-range value.
    blank_leading = 1'b1;
    msg_mode = 1'b0;
    strobe16(16'd12345);
    wait_idle(1'b1, "ovf");
    repeat (2) tick;
    capture(1'b1, "ovf");
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_dash_d%0d", i), {25'd0, cap_dig[i]}, 32'h3F);
    strobe16(16'd9999);
    wait_idle(1'b1, "ovf_clr");
    repeat (2) tick;
    capture(1'b1, "ovf_clr");
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_clr_d%0d", i), {25'd0, cap_dig[i]}, 32'h10);

    // Strobes while busy: 12, then 99, then 55 overriding 99.
    strobe8(8'd12);
    mon_en = 1'b1;
    tick;
    strobe8(8'd99);
    strobe8(8'd55);
    wait_idle(1'b0, "pend");
    repeat (2) tick;
    mon_en = 1'b0;
    chk("pend_seen12", {31'd0, seen12}, 32'd1);
    chk("pend_no99", {31'd0, seen99}, 32'd0);
    chk("pend_seen55", {31'd0, seen55}, 32'd1);
    chk("pend_busy_gap", {31'd0, gap}, 32'd0);
    chk("pend_final", {16'd0, dut.dig_buf}, 32'h0055);

    // Reset in the middle of a conversion.
    strobe8(8'd200);
    repeat (3) tick;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_seg", {25'd0, seg8}, 32'h7F);
    chk("midrst_sel", {28'd0, sel8}, 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (busy8) busy_seen++;
    end
    chk("midrst_no_resume", busy_seen, 32'd0);
    chk("midrst_buf", {16'd0, dut.dig_buf}, 32'd0);
    capture(1'b0, "midrst");
    chk("midrst_d3", {25'd0, cap_dig[3]}, 32'h7F);
    chk("midrst_d2", {25'd0, cap_dig[2]}, 32'h7F);
    chk("midrst_d1", {25'd0, cap_dig[1]}, 32'h7F);
    chk("midrst_d0", {25'd0, cap_dig[0]}, 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
